// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data cache memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Grant codes, also driven out on GRANT for status/debug
  typedef enum logic [1:0] {
    GNT_NONE   = 2'b00,
    GNT_ICACHE = 2'b01,
    GNT_DCACHE = 2'b10
  } grant_t;

  // Opposite client of a grant; NONE maps to NONE
  function automatic grant_t other_client(input grant_t g);
    case (g)
      GNT_ICACHE: other_client = GNT_DCACHE;
      GNT_DCACHE: other_client = GNT_ICACHE;
      default:    other_client = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: req[0] = icache, req[1] = dcache.
// On a tie the client that was not granted last time wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] winner
);

  grant_t last_g;

  // Interpret the previous grant code
  always_comb begin
    last_g = GNT_ICACHE;
    if (last_grant == GNT_DCACHE) begin
      last_g = GNT_DCACHE;
    end
  end

  // Winner selection: single requester wins, tie goes away from last grant
  always_comb begin
    winner = GNT_NONE;
    case (req)
      2'b01:   winner = GNT_ICACHE;
      2'b10:   winner = GNT_DCACHE;
      2'b11:   winner = other_client(last_g);
      default: winner = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the icache (read-only) and the dcache
// (read/write). One memory transaction at a time, round-robin between clients.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic [1:0]        GRANT
);

  state_t            state_q;
  state_t            state_d;
  grant_t            grant_q;
  grant_t            last_grant_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              i_req_c;
  logic              d_req_c;
  logic [1:0]        winner_c;
  logic              load_c;
  logic              complete_c;
  logic              release_c;

  assign i_req_c = I_READ;
  assign d_req_c = D_READ | D_WRITE;

  arb_rr2 u_arb (
    .req        ({d_req_c, i_req_c}),
    .last_grant (last_grant_q),
    .winner     (winner_c)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_c || d_req_c) begin
          state_d = ST_ISSUE;
        end
      end
      // Memory raises its busy flag late, so it is not looked at here
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!MEM_BUSYWAIT) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes and client stall outputs
  always_comb begin
    load_c     = 1'b0;
    complete_c = 1'b0;
    release_c  = 1'b0;
    I_BUSYWAIT = i_req_c;
    D_BUSYWAIT = d_req_c;
    case (state_q)
      ST_IDLE:    load_c     = i_req_c | d_req_c;
      ST_WAIT:    complete_c = ~MEM_BUSYWAIT;
      ST_RELEASE: begin
        release_c = 1'b1;
        if (grant_q == GNT_ICACHE) begin
          I_BUSYWAIT = 1'b0;
        end
        if (grant_q == GNT_DCACHE) begin
          D_BUSYWAIT = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Memory port, grant and read-data registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      grant_q      <= GNT_NONE;
      last_grant_q <= GNT_ICACHE;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      if (load_c) begin
        grant_q <= grant_t'(winner_c);
        if (winner_c == GNT_DCACHE) begin
          // Read and write together is treated as a write
          mem_read_q  <= D_READ & ~D_WRITE;
          mem_write_q <= D_WRITE;
          mem_addr_q  <= D_ADDRESS;
          mem_wdata_q <= D_WRITEDATA;
        end else begin
          mem_read_q  <= 1'b1;
          mem_write_q <= 1'b0;
          mem_addr_q  <= I_ADDRESS;
          mem_wdata_q <= '0;
        end
      end
      if (complete_c) begin
        mem_read_q   <= 1'b0;
        mem_write_q  <= 1'b0;
        last_grant_q <= grant_q;
        if (mem_read_q) begin
          if (grant_q == GNT_ICACHE) begin
            i_rdata_q <= MEM_READDATA;
          end
          if (grant_q == GNT_DCACHE) begin
            d_rdata_q <= MEM_READDATA;
          end
        end
      end
      if (release_c) begin
        grant_q <= GNT_NONE;
      end
    end
  end

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign I_READDATA    = i_rdata_q;
  assign D_READDATA    = d_rdata_q;
  assign GRANT         = grant_q;

endmodule
